// File: rtl/up_count_monitor.sv
// Sampling monitor for a free-running up counter: checks +1 modulo 2^WIDTH steps,
// flags wraps, upstream restarts and compare matches, and keeps a saturating wrap count.
module up_count_monitor #(
    parameter int WIDTH      = 4,
    parameter int WRAP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      count_in,
    input  logic [WIDTH-1:0]      cmp_val,
    input  logic                  clr,
    output logic                  match_pulse,
    output logic                  wrap_pulse,
    output logic                  restart_pulse,
    output logic [WRAP_WIDTH-1:0] wrap_cnt,
    output logic                  wrap_sat,
    output logic                  seq_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0]      CNT_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]      CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]      CNT_MAX   = {WIDTH{1'b1}};
    localparam logic [WRAP_WIDTH-1:0] WRAP_ZERO = {WRAP_WIDTH{1'b0}};
    localparam logic [WRAP_WIDTH-1:0] WRAP_ONE  = {{(WRAP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WRAP_WIDTH-1:0] WRAP_MAX  = {WRAP_WIDTH{1'b1}};

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        prev_q, prev_d;
    logic                    match_q, match_d;
    logic                    wrap_q, wrap_d;
    logic                    restart_q, restart_d;
    logic [WRAP_WIDTH-1:0]   wrap_cnt_q, wrap_cnt_d;
    logic                    wrap_sat_q, wrap_sat_d;
    logic                    seq_err_q, seq_err_d;

    logic [WIDTH-1:0]        exp_s;
    logic [WRAP_WIDTH-1:0]   wrap_cnt_inc_s;

    assign exp_s          = prev_q + CNT_ONE;
    assign wrap_cnt_inc_s = (wrap_cnt_q != WRAP_MAX) ? (wrap_cnt_q + WRAP_ONE) : wrap_cnt_q;

    // State and output registers, cleared asynchronously by rst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            prev_q     <= CNT_ZERO;
            match_q    <= 1'b0;
            wrap_q     <= 1'b0;
            restart_q  <= 1'b0;
            wrap_cnt_q <= WRAP_ZERO;
            wrap_sat_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            match_q    <= match_d;
            wrap_q     <= wrap_d;
            restart_q  <= restart_d;
            wrap_cnt_q <= wrap_cnt_d;
            wrap_sat_q <= wrap_sat_d;
            seq_err_q  <= seq_err_d;
        end
    end

    // Next-state: classify the new sample against the previous one
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        match_d    = 1'b0;
        wrap_d     = 1'b0;
        restart_d  = 1'b0;
        wrap_cnt_d = wrap_cnt_q;
        wrap_sat_d = wrap_sat_q;
        seq_err_d  = seq_err_q;

        if (clr) begin
            state_d    = IDLE;
            prev_d     = CNT_ZERO;
            wrap_cnt_d = WRAP_ZERO;
            wrap_sat_d = 1'b0;
            seq_err_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = TRACK;
                    prev_d  = count_in;
                    match_d = (count_in == cmp_val);
                end
                TRACK: begin
                    prev_d  = count_in;
                    // A hold (count_in == prev) must not re-fire a match
                    match_d = (count_in == cmp_val) && (count_in != prev_q);
                    if (count_in == exp_s) begin
                        if (exp_s == CNT_ZERO) begin
                            wrap_d     = 1'b1;
                            wrap_cnt_d = wrap_cnt_inc_s;
                            if (wrap_cnt_inc_s == WRAP_MAX) begin
                                wrap_sat_d = 1'b1;
                            end else begin
                                wrap_sat_d = wrap_sat_q;
                            end
                        end else begin
                            wrap_d = 1'b0;
                        end
                    end else if ((count_in == CNT_ZERO) && (prev_q != CNT_MAX) && (prev_q != CNT_ZERO)) begin
                        restart_d = 1'b1;
                    end else if (count_in == prev_q) begin
                        restart_d = 1'b0;
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    prev_d  = CNT_ZERO;
                end
            endcase
        end
    end

    assign match_pulse   = match_q;
    assign wrap_pulse    = wrap_q;
    assign restart_pulse = restart_q;
    assign wrap_cnt      = wrap_cnt_q;
    assign wrap_sat      = wrap_sat_q;
    assign seq_err       = seq_err_q;

endmodule

// File: tb/tb_up_count_monitor.sv
// Scoreboard bench for up_count_monitor: a behavioural model queues the expected
// outputs per sample; a monitor compares them one cycle after each clock edge.
module tb_up_count_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [3:0] count_in;
    logic [3:0] cmp_val;
    logic       match_pulse, wrap_pulse, restart_pulse, wrap_sat, seq_err;
    logic [7:0] wrap_cnt;

    typedef struct packed {
        logic       m;
        logic       w;
        logic       r;
        logic [7:0] cnt;
        logic       sat;
        logic       err;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_exp, mon_got;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit m_have;
    int m_prev, m_cnt;
    bit m_sat, m_err;
    int cur;

    up_count_monitor #(.WIDTH(4), .WRAP_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .cmp_val(cmp_val), .clr(clr),
        .match_pulse(match_pulse), .wrap_pulse(wrap_pulse), .restart_pulse(restart_pulse),
        .wrap_cnt(wrap_cnt), .wrap_sat(wrap_sat), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample_dut();
        obs_t o;
        o.m = match_pulse; o.w = wrap_pulse; o.r = restart_pulse;
        o.cnt = wrap_cnt; o.sat = wrap_sat; o.err = seq_err;
        return o;
    endfunction

    // Monitor: one expected record per processed clock edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = sample_dut();
            tests++;
            if (mon_got !== mon_exp) begin
                fails++;
                $display("FAIL scoreboard t=%0t: got m=%0b w=%0b r=%0b cnt=%0d sat=%0b err=%0b, expected m=%0b w=%0b r=%0b cnt=%0d sat=%0b err=%0b",
                         $time, mon_got.m, mon_got.w, mon_got.r, mon_got.cnt, mon_got.sat, mon_got.err,
                         mon_exp.m, mon_exp.w, mon_exp.r, mon_exp.cnt, mon_exp.sat, mon_exp.err);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_have = 1'b0; m_prev = 0; m_cnt = 0; m_sat = 1'b0; m_err = 1'b0;
    endtask

    // Entered at a negedge: apply inputs, queue the model's answer, wait for the next negedge
    task automatic drive(input int c, input int cmp, input bit cl);
        obs_t e;
        int   nxt;
        count_in = c[3:0];
        cmp_val  = cmp[3:0];
        clr      = cl;
        e = '0;
        c = c % 16;
        cmp = cmp % 16;
        if (cl) begin
            model_reset();
        end else if (!m_have) begin
            e.m = (c == cmp);
            m_have = 1'b1;
            m_prev = c;
        end else begin
            nxt = (m_prev + 1) % 16;
            e.m = (c == cmp) && (c != m_prev);
            if (c == nxt && nxt == 0) begin
                e.w = 1'b1;
                if (m_cnt < 255) m_cnt++;
                if (m_cnt == 255) m_sat = 1'b1;
            end else if (c == nxt) begin
                e.w = 1'b0;
            end else if (c == 0 && m_prev != 15 && m_prev != 0) begin
                e.r = 1'b1;
            end else if (c != m_prev) begin
                m_err = 1'b1;
            end
            m_prev = c;
        end
        e.cnt = m_cnt[7:0];
        e.sat = m_sat;
        e.err = m_err;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Entered at a negedge: asynchronous reset, outputs checked without a clock edge
    task automatic do_reset();
        obs_t o;
        rst = 1'b0;
        #1;
        o = sample_dut();
        chk("async_reset_outputs", int'(o), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; count_in = 4'd0; cmp_val = 4'd0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Full count sequence with one wrap and one match
        for (int i = 0; i < 16; i++) drive(i, 5, 1'b0);
        drive(0, 5, 1'b0);
        drive(1, 5, 1'b0);
        chk("first_wrap_cnt", int'(wrap_cnt), 1);
        chk("first_seq_err", int'(seq_err), 0);

        // Saturation of the wrap counter
        drive(0, 0, 1'b1);
        for (int k = 0; k < 300; k++)
            for (int i = 0; i < 16; i++) drive(i, 3, 1'b0);
        drive(0, 3, 1'b0);
        chk("sat_wrap_cnt", int'(wrap_cnt), 255);
        chk("sat_flag", int'(wrap_sat), 1);

        // Skipped value then resumed stepping
        drive(0, 0, 1'b1);
        drive(3, 0, 1'b0); drive(4, 0, 1'b0); drive(7, 0, 1'b0); drive(8, 0, 1'b0);
        chk("skip_seq_err", int'(seq_err), 1);

        // Upstream restart
        drive(0, 0, 1'b1);
        drive(6, 0, 1'b0); drive(7, 0, 1'b0); drive(0, 0, 1'b0); drive(1, 0, 1'b0);
        chk("restart_seq_err", int'(seq_err), 0);

        // Holds with a matching compare value
        drive(0, 9, 1'b1);
        drive(9, 9, 1'b0); drive(9, 9, 1'b0); drive(9, 9, 1'b0); drive(10, 9, 1'b0);

        // Reset mid-sequence, then clear with seq_err set
        drive(10, 2, 1'b0); drive(11, 2, 1'b0); drive(12, 2, 1'b0);
        do_reset();
        drive(2, 2, 1'b0); drive(3, 2, 1'b0); drive(5, 2, 1'b0); drive(6, 2, 1'b0);
        chk("pre_clr_seq_err", int'(seq_err), 1);
        drive(7, 2, 1'b1);
        chk("clr_outputs", int'(sample_dut()), 0);
        drive(13, 2, 1'b0); drive(14, 2, 1'b0);
        chk("post_clr_seq_err", int'(seq_err), 0);

        // Randomised traffic
        cur = 14;
        cmp_val = 4'd0;
        for (int n = 0; n < 4000; n++) begin
            int r;
            int cmp;
            r = int'($urandom_range(0, 999));
            cmp = (n % 40 == 0) ? int'($urandom_range(0, 15)) : int'(cmp_val);
            if (r < 10) begin
                do_reset();
            end else if (r < 40) begin
                drive(cur, cmp, 1'b1);
            end else begin
                if (r < 750)      cur = (cur + 1) % 16;
                else if (r < 830) cur = cur;
                else if (r < 900) cur = 0;
                else              cur = int'($urandom_range(0, 15));
                drive(cur, cmp, 1'b0);
            end
        end

        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
